// File: rtl/array_ctrl.sv
// Row-decoder sequencer for a small memory/CAM/MAC array: accepts one command at a time,
// drives the decoder controls, waits for the self-timed sense and returns one response per row.
module array_ctrl #(
  parameter int unsigned WRITE_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [1:0] req_addr,
  input  logic [3:0] req_data,
  input  logic       req_read_bar,
  output logic       cs,
  output logic       w_en,
  output logic       MAC_en,
  output logic       read_bar,
  output logic [1:0] addr,
  output logic [3:0] data,
  input  logic       sense_done,
  input  logic [3:0] sense_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_data,
  output logic [1:0] rsp_row,
  output logic       rsp_err
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;
  typedef enum logic [1:0] {OP_WRITE = 2'b00, OP_CAM = 2'b01, OP_MAC = 2'b10, OP_SCAN = 2'b11} op_t;

  typedef struct packed {
    logic       w_en;
    logic       mac_en;
    logic       read_bar;
    logic [1:0] addr;
    logic [3:0] data;
  } mode_t;

  localparam logic [3:0] WR_LAST = 4'(WRITE_CYCLES - 1);
  localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);

  state_t     r_state;
  op_t        r_op;
  logic [1:0] r_addr;
  logic [3:0] r_data;
  logic       r_rb;
  logic [1:0] r_row;
  logic [3:0] r_cnt;
  logic       r_cs;
  mode_t      r_mode;
  logic       r_rsp_valid;
  logic [3:0] r_rsp_data;
  logic [1:0] r_rsp_row;
  logic       r_rsp_err;

  logic       w_done;
  logic       w_err;
  logic [3:0] w_rdata;
  logic       w_scan_more;

  // Decoder drive for one row access; scan replaces the address with the row counter.
  function automatic mode_t decode(op_t op, logic [1:0] a, logic [3:0] d, logic rb, logic [1:0] row);
    mode_t m;
    m = '0;
    unique case (op)
      OP_WRITE: begin m.w_en = 1'b1; m.addr = a; m.data = d; end
      OP_CAM:   m.data = d;
      OP_MAC:   begin m.mac_en = 1'b1; m.read_bar = rb; m.addr = a; end
      OP_SCAN:  begin m.mac_en = 1'b1; m.read_bar = rb; m.addr = row; end
    endcase
    return m;
  endfunction

  // NOTE: every variable gets a default before the ifs so no latch is inferred.
  always_comb begin
    w_done  = 1'b0;
    w_err   = 1'b0;
    w_rdata = '0;
    if (r_op == OP_WRITE) begin
      w_done  = (r_cnt == WR_LAST);
      w_rdata = r_data;
    end else if (sense_done) begin
      w_done  = 1'b1;
      w_rdata = sense_data;
    end else if (r_cnt == TO_LAST) begin
      w_done = 1'b1;
      w_err  = 1'b1;
    end
  end

  assign w_scan_more = (r_op == OP_SCAN) && (r_row != 2'd3) && !r_rsp_err;

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= OP_WRITE;
      r_addr      <= '0;
      r_data      <= '0;
      r_rb        <= 1'b0;
      r_row       <= '0;
      r_cnt       <= '0;
      r_cs        <= 1'b0;
      r_mode      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_row   <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op    <= op_t'(req_op);
            r_addr  <= req_addr;
            r_data  <= req_data;
            r_rb    <= req_read_bar;
            r_row   <= '0;
            r_cs    <= 1'b1;
            r_mode  <= decode(op_t'(req_op), req_addr, req_data, req_read_bar, 2'd0);
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_cnt   <= '0;
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          r_cnt <= r_cnt + 4'd1;
          if (w_done) begin
            r_cs        <= 1'b0;
            r_mode      <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_rdata;
            r_rsp_row   <= r_mode.addr;
            r_rsp_err   <= w_err;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (w_scan_more) begin
              r_row   <= r_row + 2'd1;
              r_cs    <= 1'b1;
              r_mode  <= decode(r_op, r_addr, r_data, r_rb, r_row + 2'd1);
              r_state <= S_SETUP;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign cs        = r_cs;
  assign w_en      = r_mode.w_en;
  assign MAC_en    = r_mode.mac_en;
  assign read_bar  = r_mode.read_bar;
  assign addr      = r_mode.addr;
  assign data      = r_mode.data;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_row   = r_rsp_row;
  assign rsp_err   = r_rsp_err;

endmodule
